// File: rtl/symmetry_scanner_pkg.sv
// symmetry_pkg: shared types and helpers for the symmetry scanner.
//   state_t     : controller states IDLE -> SCAN -> DONE
//   MODE_MIRROR : bit k must equal bit WIDTH-1-k
//   MODE_ANTI   : bit k must equal the complement of bit WIDTH-1-k
//   cw_of()     : width of the mismatch count / pair index (holds 0..WIDTH/2)
package symmetry_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_MIRROR = 1'b0;
   localparam logic MODE_ANTI   = 1'b1;

   function automatic int cw_of(input int width);
      return $clog2(width / 2 + 1);
   endfunction

endpackage

// File: rtl/symmetry_scanner_if.sv
// symmetry_scanner_if: word-in / result-out bus of the symmetry scanner.
//   in_valid/in_ready/in_data/in_mode             : input word channel
//   out_valid/out_ready/out_sym/out_mis_cnt/
//   out_first_mis                                 : result channel
//   busy                                          : scanner is in SCAN or DONE
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holding valid keeps its payload stable until that edge; the
// sink's ready may change freely and has no combinational path to valid.
// Modports: slave = the scanner, master = the producer/consumer side.
interface symmetry_scanner_if
   import symmetry_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = cw_of(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic             out_sym;
   logic [CW-1:0]    out_mis_cnt;
   logic [CW-1:0]    out_first_mis;
   logic             busy;

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_sym, out_mis_cnt, out_first_mis, busy
   );

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_sym, out_mis_cnt, out_first_mis, busy
   );
endinterface

// File: rtl/symmetry_scanner_pair_compare_lanes.sv
// pair_compare_lanes: combinational comparison of LANES mirrored bit pairs.
// Pair k compares bit k with bit WIDTH-1-k; the pairs handled in one step
// are k = step*LANES .. step*LANES+LANES-1.
//   word       in  latched word
//   step       in  step index
//   mode       in  MODE_MIRROR / MODE_ANTI
//   mis_cnt    out number of mismatching pairs in this step
//   any_mis    out at least one pair of this step mismatched
//   first_lane out lowest mismatching lane (0 when none)
module pair_compare_lanes #(
   parameter int WIDTH = 8,
   parameter int LANES = 1,
   parameter int CW    = 3,
   parameter int SW    = 2,
   parameter int LW    = 1
) (
   input  logic [WIDTH-1:0] word,
   input  logic [SW-1:0]    step,
   input  logic             mode,
   output logic [CW-1:0]    mis_cnt,
   output logic             any_mis,
   output logic [LW-1:0]    first_lane
);
   logic [WIDTH-1:0] rev;
   logic [WIDTH-1:0] diff;
   logic [LANES-1:0] lane_mis;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign rev[i] = word[WIDTH-1-i];
   end

   // diff[k] = 1 when pair k breaks the rule; in anti-mirror mode equal bits
   // are the failure, so the XOR is inverted.
   assign diff     = word ^ rev ^ {WIDTH{mode}};
   assign lane_mis = LANES'(diff >> (int'(step) * LANES));

   always_comb begin
      mis_cnt    = '0;
      any_mis    = |lane_mis;
      first_lane = '0;
      // Walk downwards so the lowest mismatching lane is written last.
      for (int l = LANES - 1; l >= 0; l--) begin
         mis_cnt = mis_cnt + CW'(lane_mis[l]);
         if (lane_mis[l]) begin
            first_lane = LW'(l);
         end
      end
   end
endmodule

// File: rtl/symmetry_scanner.sv
// symmetry_scanner: sequential mirrored-pair checker.
// Accepts a WIDTH-bit word, scans LANES pairs per clock for WIDTH/2 pairs
// (middle bit of odd widths is skipped) and presents symmetric flag,
// mismatch count and lowest mismatching pair index (WIDTH/2 when none).
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : symmetry_scanner_if slave (input word / result channels)
//   dbg_state   : current controller state
//   stat_words, stat_sym : result / symmetric-result counters, present only
//                 when SYM_STATS_EN is defined (saturating, 16 bit)
module symmetry_scanner
   import symmetry_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 1
) (
   input  logic              clk,
   input  logic              rst,
   symmetry_scanner_if.slave bus,
   output state_t            dbg_state
`ifdef SYM_STATS_EN
   ,
   output logic [15:0]       stat_words,
   output logic [15:0]       stat_sym
`endif
);
   localparam int P     = WIDTH / 2;
   localparam int CW    = cw_of(WIDTH);
   localparam int STEPS = (LANES > 0) ? P / LANES : 1;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   if (WIDTH < 2 || LANES < 1 || (P % LANES) != 0) begin : g_bad_cfg
      $error("symmetry_scanner: WIDTH must be >= 2 and LANES must divide WIDTH/2");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] word;
   logic             mode;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    first;
   logic [SW-1:0]    step;
   logic [CW-1:0]    step_cnt;
   logic             step_any;
   logic [LW-1:0]    step_lane;

   pair_compare_lanes #(
      .WIDTH(WIDTH), .LANES(LANES), .CW(CW), .SW(SW), .LW(LW)
   ) u_lanes (
      .word       (word),
      .step       (step),
      .mode       (mode),
      .mis_cnt    (step_cnt),
      .any_mis    (step_any),
      .first_lane (step_lane)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_sym   = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = SCAN;
         end
         SCAN: begin
            bus.busy = 1'b1;
            if (step == SW'(STEPS - 1)) state_nxt = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            bus.out_sym   = (cnt == '0);
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word  <= '0;
         mode  <= MODE_MIRROR;
         cnt   <= '0;
         first <= '0;
         step  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  word  <= bus.in_data;
                  mode  <= bus.in_mode;
                  cnt   <= '0;
                  first <= CW'(P);
                  step  <= '0;
               end
            end
            SCAN: begin
               cnt  <= cnt + step_cnt;
               step <= step + SW'(1);
               // Only the first step that sees a mismatch sets the index.
               if (first == CW'(P) && step_any) begin
                  first <= CW'(int'(step) * LANES + int'(step_lane));
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_mis_cnt   = cnt;
   assign bus.out_first_mis = first;
   assign dbg_state         = state;

`ifdef SYM_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_words <= '0;
         stat_sym   <= '0;
      end else if (state == DONE && bus.out_ready) begin
         if (stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
         if (cnt == '0 && stat_sym != 16'hFFFF) stat_sym <= stat_sym + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_symmetry_scanner.sv
// tb_symmetry_scanner: checks a WIDTH=8/LANES=1 and a WIDTH=9/LANES=2
// scanner. Build with SYM_STATS_EN defined to also check the counters.
module tb_symmetry_scanner;
   import symmetry_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   symmetry_scanner_if #(.WIDTH(8)) bus8 ();
   symmetry_scanner_if #(.WIDTH(9)) bus9 ();
   state_t st8, st9;
`ifdef SYM_STATS_EN
   logic [15:0] sw8, ss8, sw9, ss9;
`endif

   symmetry_scanner #(.WIDTH(8), .LANES(1)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8.slave), .dbg_state(st8)
`ifdef SYM_STATS_EN
      , .stat_words(sw8), .stat_sym(ss8)
`endif
   );

   symmetry_scanner #(.WIDTH(9), .LANES(2)) dut9 (
      .clk(clk), .rst(rst), .bus(bus9.slave), .dbg_state(st9)
`ifdef SYM_STATS_EN
      , .stat_words(sw9), .stat_sym(ss9)
`endif
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   int exp_words = 0;   // result handshakes expected on dut8 since reset
   int exp_syms  = 0;
   logic [6:0] exp_q[$];   // {sym, mis_cnt, first_mis}

   typedef struct {
      bit         w9;
      logic [8:0] data;
      logic       mode;
      logic [6:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the pairs and apply the mirror / anti-mirror rule.
   function automatic logic [6:0] model(input logic [8:0] w, input logic m, input int width);
      int p, cnt, first;
      logic a, b, broken;
      p = width / 2;
      cnt = 0;
      first = p;
      for (int k = 0; k < p; k++) begin
         a = w[k];
         b = w[width-1-k];
         broken = (m == MODE_MIRROR) ? (a != b) : (a == b);
         if (broken) begin
            cnt++;
            if (first == p) first = k;
         end
      end
      return {cnt == 0, 3'(cnt), 3'(first)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit w9, input logic v, input logic [8:0] d, input logic m);
      if (w9) begin
         bus9.in_valid = v; bus9.in_data = d; bus9.in_mode = m;
      end else begin
         bus8.in_valid = v; bus8.in_data = d[7:0]; bus8.in_mode = m;
      end
   endtask

   task automatic set_ready(input bit w9, input logic r);
      if (w9) bus9.out_ready = r;
      else    bus8.out_ready = r;
   endtask

   task automatic sample(input bit w9, output logic rdy, output logic ov,
                         output logic [6:0] res, output logic bsy);
      if (w9) begin
         rdy = bus9.in_ready; ov = bus9.out_valid; bsy = bus9.busy;
         res = {bus9.out_sym, bus9.out_mis_cnt, bus9.out_first_mis};
      end else begin
         rdy = bus8.in_ready; ov = bus8.out_valid; bsy = bus8.busy;
         res = {bus8.out_sym, bus8.out_mis_cnt, bus8.out_first_mis};
      end
   endtask

   // One full transaction: accept, wait for the result, optionally stall
   // the consumer, compare with the head of exp_q, drain.
   task automatic run_word(input bit w9, input logic [8:0] d, input logic m,
                           input int stall, input int steps, input string name);
      int n;
      logic rdy, ov, bsy;
      logic [6:0] res, exp;
      exp = 7'h0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      n = 0;
      sample(w9, rdy, ov, res, bsy);
      while (!rdy && n < 50) begin
         tick; n++;
         sample(w9, rdy, ov, res, bsy);
      end
      chk({name, " in_ready"}, 32'(rdy), 32'd1);
      set_ready(w9, stall == 0);
      drive(w9, 1'b1, d, m);
      tick;
      drive(w9, 1'b0, 9'h0, 1'b0);
      n = 0;
      sample(w9, rdy, ov, res, bsy);
      while (!ov && n < 50) begin
         tick; n++;
         sample(w9, rdy, ov, res, bsy);
      end
      chk({name, " latency"}, 32'(n), 32'(steps));
      for (int i = 0; i < stall; i++) begin
         tick;
         sample(w9, rdy, ov, res, bsy);
         chk({name, " held result"}, 32'({ov, res}), 32'({1'b1, exp}));
      end
      set_ready(w9, 1'b1);
      sample(w9, rdy, ov, res, bsy);
      chk({name, " out_valid"}, 32'(ov), 32'd1);
      chk({name, " result"}, 32'(res), 32'(exp));
      tick;
      sample(w9, rdy, ov, res, bsy);
      chk({name, " drained"}, 32'(ov), 32'd0);
      if (!w9) begin
         exp_words++;
         if (exp[6]) exp_syms++;
      end
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[9];

   initial begin
      logic rdy, ov, bsy;
      logic [6:0] res;
      logic [8:0] rd;
      logic rm;
      int n;

      vecs[0] = '{1'b0, 9'h0A5, MODE_MIRROR, 7'b1_000_100};
      vecs[1] = '{1'b0, 9'h00F, MODE_MIRROR, 7'b0_100_000};
      vecs[2] = '{1'b0, 9'h00F, MODE_ANTI,   7'b1_000_100};
      vecs[3] = '{1'b0, 9'h010, MODE_MIRROR, 7'b0_001_011};
      vecs[4] = '{1'b0, 9'h081, MODE_ANTI,   7'b0_100_000};
      vecs[5] = '{1'b0, 9'h0FF, MODE_MIRROR, 7'b1_000_100};
      // 9-bit: middle bit 4 never takes part
      vecs[6] = '{1'b1, 9'b1_0110_1101, MODE_MIRROR, 7'b1_000_100};
      vecs[7] = '{1'b1, 9'h00C, MODE_MIRROR, 7'b0_010_010};
      vecs[8] = '{1'b1, 9'h010, MODE_ANTI,   7'b0_100_000};

      drive(1'b0, 1'b0, 9'h0, 1'b0);
      drive(1'b1, 1'b0, 9'h0, 1'b0);
      set_ready(1'b0, 1'b1);
      set_ready(1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // reset state
      sample(1'b0, rdy, ov, res, bsy);
      chk("rst in_ready", 32'(rdy), 32'd1);
      chk("rst out_valid", 32'(ov), 32'd0);
      chk("rst result", 32'(res), 32'd0);
      chk("rst busy", 32'(bsy), 32'd0);
      chk("rst state", 32'(st8), 32'(IDLE));
      sample(1'b1, rdy, ov, res, bsy);
      chk("rst9 outputs", 32'({rdy, ov, res, bsy}), 32'({1'b1, 1'b0, 7'h0, 1'b0}));
      @(negedge clk);
      rst = 1'b0;
      tick;

      // table vectors
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(vecs[i].exp);
         run_word(vecs[i].w9, vecs[i].data, vecs[i].mode, 0,
                  vecs[i].w9 ? 2 : 4, $sformatf("vec%0d", i));
      end
`ifdef SYM_STATS_EN
      chk("stat_words table", 32'(sw8), 32'(exp_words));
      chk("stat_sym table", 32'(ss8), 32'(exp_syms));
`endif

      // back-pressure: result held, second word must wait for the drain
      set_ready(1'b0, 1'b0);
      drive(1'b0, 1'b1, 9'h00F, MODE_MIRROR);
      tick;
      drive(1'b0, 1'b1, 9'h0A5, MODE_MIRROR);
      n = 0;
      sample(1'b0, rdy, ov, res, bsy);
      while (!ov && n < 50) begin
         tick; n++;
         sample(1'b0, rdy, ov, res, bsy);
      end
      chk("bp latency", 32'(n), 32'd4);
      for (int i = 0; i < 10; i++) begin
         sample(1'b0, rdy, ov, res, bsy);
         chk("bp hold", 32'({ov, rdy, res}), 32'({1'b1, 1'b0, 7'b0_100_000}));
         tick;
      end
      set_ready(1'b0, 1'b1);
      tick;
      sample(1'b0, rdy, ov, res, bsy);
      chk("bp after drain", 32'({ov, rdy, bsy}), 32'({1'b0, 1'b1, 1'b0}));
      tick;
      drive(1'b0, 1'b0, 9'h0, 1'b0);
      n = 0;
      sample(1'b0, rdy, ov, res, bsy);
      while (!ov && n < 50) begin
         tick; n++;
         sample(1'b0, rdy, ov, res, bsy);
      end
      chk("bp second latency", 32'(n), 32'd4);
      chk("bp second result", 32'(res), 32'(7'b1_000_100));
      tick;
      exp_words += 2;
      exp_syms  += 1;

      // reset in the middle of a scan
      drive(1'b0, 1'b1, 9'h00F, MODE_MIRROR);
      tick;
      drive(1'b0, 1'b0, 9'h0, 1'b0);
      tick;
      tick;
      rst = 1'b1;
      #1;
      sample(1'b0, rdy, ov, res, bsy);
      chk("mid-scan rst", 32'({ov, rdy, bsy}), 32'({1'b0, 1'b1, 1'b0}));
      chk("mid-scan rst state", 32'(st8), 32'(IDLE));
`ifdef SYM_STATS_EN
      chk("stat rst", 32'({sw8, ss8}), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      exp_words = 0;
      exp_syms  = 0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         sample(1'b0, rdy, ov, res, bsy);
         if (ov) n++;
      end
      chk("no partial result", 32'(n), 32'd0);
      exp_q.push_back(7'b1_000_100);
      run_word(1'b0, 9'h0FF, MODE_MIRROR, 0, 4, "after rst");

      // randomized words with random consumer stalls
      for (int i = 0; i < 30; i++) begin
         rd = 9'($urandom_range(0, 255));
         rm = 1'($urandom_range(0, 1));
         exp_q.push_back(model(rd, rm, 8));
         run_word(1'b0, rd, rm, $urandom_range(0, 3), 4, "rand8");
      end
      for (int i = 0; i < 30; i++) begin
         rd = 9'($urandom_range(0, 511));
         rm = 1'($urandom_range(0, 1));
         exp_q.push_back(model(rd, rm, 9));
         run_word(1'b1, rd, rm, $urandom_range(0, 2), 2, "rand9");
      end

`ifdef SYM_STATS_EN
      chk("stat_words final", 32'(sw8), 32'(exp_words));
      chk("stat_sym final", 32'(ss8), 32'(exp_syms));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop if something wedges the sequence
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
